// File: rtl/rect_reader.sv
// Streams a rectangular region of a column-major RGB frame buffer out as a pixel
// stream, throttling RAM reads so every returning word is guaranteed a FIFO slot.
module rect_reader #(
  parameter int FB_COLS    = 160,
  parameter int FB_ROWS    = 120,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  col_start,
  input  logic [6:0]  row_start,
  input  logic [7:0]  width,
  input  logic [6:0]  height,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [14:0] mem_rd_addr,
  output logic        mem_rd_en,
  input  logic [23:0] mem_rd_data,
  output logic [23:0] pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [14:0] ROW_STRIDE = 15'(FB_ROWS);

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_DRAIN, S_FIN} state_t;

  state_t                r_state;
  logic [7:0]            r_col, r_width, r_i;
  logic [6:0]            r_row, r_height, r_j;
  logic [14:0]           r_addr, r_col_addr;
  logic                  r_busy, r_done, r_err;
  logic [CW-1:0]         r_infl, r_cnt;
  logic [RD_LATENCY-1:0] r_pipe_vld, r_pipe_last;
  logic [23:0]           r_fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] r_fifo_last;
  logic [AW-1:0]         r_wp, r_rp;

  logic        w_zero, w_oob, w_credit, w_issue, w_last_issue, w_push, w_pop, w_valid;
  logic [14:0] w_base;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_zero       = (r_width == 8'd0) || (r_height == 7'd0);
  assign w_oob        = ({1'b0, r_col} + {1'b0, r_width} > 9'(FB_COLS)) ||
                        ({1'b0, r_row} + {1'b0, r_height} > 8'(FB_ROWS));
  assign w_base       = 15'(r_col) * ROW_STRIDE + 15'(r_row);
  assign w_credit     = (32'(r_infl) + 32'(r_cnt)) < 32'(FIFO_DEPTH);
  assign w_issue      = (r_state == S_ISSUE) && w_credit;
  assign w_last_issue = (r_i == r_width - 8'd1) && (r_j == r_height - 7'd1);
  assign w_push       = r_pipe_vld[RD_LATENCY-1];
  assign w_valid      = (r_cnt != '0);
  assign w_pop        = w_valid && pix_ready;

  assign busy        = r_busy;
  assign done        = r_done;
  assign err         = r_err;
  assign mem_rd_en   = w_issue;
  assign mem_rd_addr = r_addr;
  assign pix_valid   = w_valid;
  assign pix_data    = w_valid ? r_fifo_data[r_rp] : '0;
  assign pix_last    = w_valid && r_fifo_last[r_rp];

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_col    <= col_start;
      r_row    <= row_start;
      r_width  <= width;
      r_height <= height;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_i        <= '0;
      r_j        <= '0;
      r_addr     <= '0;
      r_col_addr <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_err   <= 1'b0;
          r_busy  <= 1'b1;
          r_state <= S_CHECK;
        end
        S_CHECK: begin
          if (w_zero || w_oob) begin
            r_err   <= w_oob && !w_zero;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_i        <= '0;
            r_j        <= '0;
            r_addr     <= w_base;
            r_col_addr <= w_base;
            r_state    <= S_ISSUE;
          end
        end
        // Row index runs fastest; a column wrap jumps the base by one frame column.
        S_ISSUE: if (w_issue) begin
          if (r_j == r_height - 7'd1) begin
            r_j        <= '0;
            r_i        <= r_i + 8'd1;
            r_col_addr <= r_col_addr + ROW_STRIDE;
            r_addr     <= r_col_addr + ROW_STRIDE;
            if (r_i == r_width - 8'd1) r_state <= S_DRAIN;
          end else begin
            r_j    <= r_j + 7'd1;
            r_addr <= r_addr + 15'd1;
          end
        end
        S_DRAIN: if (w_pop && pix_last) begin
          r_done  <= 1'b1;
          r_state <= S_FIN;
        end
        S_FIN: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Read-return stage: valid bits track each strobe until its data arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe_vld <= '0;
      r_infl     <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      for (int k = 1; k < RD_LATENCY; k++) r_pipe_vld[k] <= r_pipe_vld[k-1];
      case ({w_issue, w_push})
        2'b10:   r_infl <= r_infl + CW'(1);
        2'b01:   r_infl <= r_infl - CW'(1);
        default: r_infl <= r_infl;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    r_pipe_last[0] <= w_issue && w_last_issue;
    for (int k = 1; k < RD_LATENCY; k++) r_pipe_last[k] <= r_pipe_last[k-1];
  end

  // Output FIFO stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= ptr_inc(r_wp);
      if (w_pop)  r_rp <= ptr_inc(r_rp);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wp] <= mem_rd_data;
      r_fifo_last[r_wp] <= r_pipe_last[RD_LATENCY-1];
    end
  end

endmodule

// File: tb/tb_rect_reader.sv
// Scoreboard bench for rect_reader: a RAM model returns data equal to address,
// expected addresses and pixels are queued at stimulus time and popped on output.
module tb_rect_reader;
  localparam int FB_COLS    = 160;
  localparam int FB_ROWS    = 120;
  localparam int RD_LATENCY = 2;
  localparam int FIFO_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, start, pix_ready;
  logic [7:0]  col_start, width;
  logic [6:0]  row_start, height;
  logic        busy, done, err, mem_rd_en, pix_valid, pix_last;
  logic [14:0] mem_rd_addr;
  logic [23:0] mem_rd_data, pix_data;

  always #5 clk = ~clk;

  rect_reader #(
    .FB_COLS(FB_COLS), .FB_ROWS(FB_ROWS), .RD_LATENCY(RD_LATENCY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .col_start(col_start), .row_start(row_start), .width(width), .height(height),
    .busy(busy), .done(done), .err(err),
    .mem_rd_addr(mem_rd_addr), .mem_rd_en(mem_rd_en), .mem_rd_data(mem_rd_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last)
  );

  logic [23:0] ram_pipe [RD_LATENCY];
  always @(posedge clk) begin
    ram_pipe[0] <= mem_rd_en ? 24'(mem_rd_addr) : 24'hDEAD00;
    for (int k = 1; k < RD_LATENCY; k++) ram_pipe[k] <= ram_pipe[k-1];
  end
  assign mem_rd_data = ram_pipe[RD_LATENCY-1];

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  logic [14:0] q_addr [$];
  logic [24:0] q_pix  [$];

  int          issued = 0, popped = 0, npix = 0, n_en = 0, n_vld = 0, done_cnt = 0;
  int          rise_cyc = 0, last_cyc = 0, done_cyc = 0;
  logic        done_err = 1'b0, prev_stall = 1'b0, prev_vld = 1'b0, prev_last = 1'b0;
  logic [23:0] prev_data = '0;
  logic [24:0] exp_pix;

  always @(negedge clk) begin
    if (rst) begin
      issued     = 0;
      popped     = 0;
      prev_stall = 1'b0;
      prev_vld   = 1'b0;
    end else begin
      if (mem_rd_en) begin
        n_en++;
        issued++;
        if (q_addr.size() == 0) chk("rd_extra", 32'(q_addr.size()), 1);
        else chk("rd_addr", 32'(mem_rd_addr), 32'(q_addr.pop_front()));
        chk("credit", 32'(issued - popped > FIFO_DEPTH), 0);
      end
      if (prev_stall) begin
        chk("hold_vld", 32'(pix_valid), 1);
        chk("hold_data", 32'(pix_data), 32'(prev_data));
        chk("hold_last", 32'(pix_last), 32'(prev_last));
      end
      if (pix_valid) begin
        n_vld++;
        if (!prev_vld) rise_cyc = cyc;
      end
      prev_vld   = pix_valid;
      prev_stall = pix_valid && !pix_ready;
      prev_data  = pix_data;
      prev_last  = pix_last;
      if (pix_valid && pix_ready) begin
        popped++;
        npix++;
        if (pix_last) last_cyc = cyc;
        if (q_pix.size() == 0) chk("pix_extra", 32'(q_pix.size()), 1);
        else begin
          exp_pix = q_pix.pop_front();
          chk("pix_data", 32'(pix_data), 32'(exp_pix[23:0]));
          chk("pix_last", 32'(pix_last), 32'(exp_pix[24]));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        done_err = err;
      end
    end
  end

  int s_last;

  // mode 0: ready high, 1: random ready, 2: ready held low ~20 cycles, 3: ready high plus a start pulse while busy
  task automatic run_region(input int c, input int r, input int w, input int h, input int mode);
    int   s, nexp, a, b_en, b_pix, b_done, b_vld, b_iss;
    logic oob, ok;
    oob  = (c + w > FB_COLS) || (r + h > FB_ROWS);
    ok   = !oob && (w != 0) && (h != 0);
    nexp = ok ? w * h : 0;
    if (ok) begin
      for (int i = 0; i < w; i++) begin
        for (int j = 0; j < h; j++) begin
          a = (c + i) * FB_ROWS + (r + j);
          q_addr.push_back(15'(a));
          q_pix.push_back({(i == w - 1) && (j == h - 1), 24'(a)});
        end
      end
    end
    b_en = n_en; b_pix = npix; b_done = done_cnt; b_vld = n_vld; b_iss = issued;
    pix_ready = (mode != 2);
    start     = 1'b1;
    col_start = 8'(c);
    row_start = 7'(r);
    width     = 8'(w);
    height    = 7'(h);
    s         = cyc;
    for (int k = 0; k < nexp * 4 + 60 && done_cnt == b_done; k++) begin
      @(posedge clk); #1;
      start = (mode == 3) && (cyc == s + 4);
      if (start) begin
        col_start = 8'd0; row_start = 7'd0; width = 8'd1; height = 7'd1;
      end
      if (cyc == s + 1) chk("err_clr", 32'(err), 0);
      case (mode)
        1:       pix_ready = 1'($urandom_range(0, 1));
        2:       pix_ready = (cyc > s + 21);
        default: pix_ready = 1'b1;
      endcase
      if (mode == 2 && cyc == s + 22) chk("stall_reads", 32'(issued - b_iss), FIFO_DEPTH);
    end
    start     = 1'b0;
    pix_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("done_cnt", 32'(done_cnt - b_done), 1);
    chk("done_err", 32'(done_err), 32'(oob));
    chk("err_sticky", 32'(err), 32'(oob));
    chk("busy_idle", 32'(busy), 0);
    chk("npix", 32'(npix - b_pix), 32'(nexp));
    chk("reads", 32'(n_en - b_en), 32'(nexp));
    chk("q_pix_left", 32'(q_pix.size()), 0);
    chk("q_addr_left", 32'(q_addr.size()), 0);
    if (nexp == 0) begin
      chk("no_valid", 32'(n_vld - b_vld), 0);
      chk("fin_lat", 32'(done_cyc - s), 2);
    end else begin
      chk("done_after_last", 32'(done_cyc - last_cyc), 1);
    end
    s_last = s;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_err"}, 32'(err), 0);
    chk({tag, "_rd_en"}, 32'(mem_rd_en), 0);
    chk({tag, "_rd_addr"}, 32'(mem_rd_addr), 0);
    chk({tag, "_valid"}, 32'(pix_valid), 0);
    chk({tag, "_last"}, 32'(pix_last), 0);
    chk({tag, "_data"}, 32'(pix_data), 0);
  endtask

  initial begin
    int s, b_en;
    rst = 1'b1; start = 1'b0; pix_ready = 1'b1;
    col_start = '0; row_start = '0; width = '0; height = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("rst");
    rst = 1'b0;

    run_region(2, 3, 4, 2, 0);
    chk("first_vld_lat", 32'(rise_cyc - s_last), RD_LATENCY + 3);
    chk("burst_len", 32'(last_cyc - rise_cyc), 7);

    run_region(150, 0, 11, 1, 0);
    run_region(0, 115, 1, 6, 0);
    run_region(10, 10, 0, 5, 0);
    run_region(7, 100, 3, 5, 3);
    run_region(0, 0, 1, 10, 2);

    for (int i = 0; i < 10; i++) q_addr.push_back(15'(i));
    b_en = n_en;
    pix_ready = 1'b1;
    start = 1'b1; col_start = 8'd0; row_start = 7'd0; width = 8'd1; height = 7'd10;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("pre_rst_reads", 32'(n_en - b_en), 3);
    chk("pre_rst_cyc", 32'(cyc - s), 5);
    rst = 1'b1;
    #1;
    chk_zero_outputs("mid_rst");
    q_addr.delete();
    q_pix.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    run_region(5, 7, 1, 1, 0);

    run_region(0, 0, 160, 120, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rect_reader.md
RECT_READER -- requirements
Module: rect_reader

Interface
REQ-001 Parameter FB_COLS, default 160, frame-buffer columns.
REQ-002 Parameter FB_ROWS, default 120, frame-buffer rows; word address = col*FB_ROWS + row (column-major, 0..19199).
REQ-003 Parameter RD_LATENCY, default 2, cycles from mem_rd_en to valid mem_rd_data.
REQ-004 Parameter FIFO_DEPTH, default 4, output buffer entries.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 start  in  1  request pulse; sampled only in IDLE.
REQ-008 col_start  in  8  leftmost column of region.
REQ-009 row_start  in  7  top row of region.
REQ-010 width  in  8  region columns.
REQ-011 height  in  7  region rows.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 done  out  1  one-cycle completion pulse.
REQ-014 err  out  1  region out of bounds; sticky until next accepted start.
REQ-015 mem_rd_addr  out  15  read address to frame-buffer RAM.
REQ-016 mem_rd_en  out  1  read strobe, one word per cycle high.
REQ-017 mem_rd_data  in  24  RGB read data, RD_LATENCY after strobe.
REQ-018 pix_data  out  24  output pixel.
REQ-019 pix_valid  out  1  pix_data valid.
REQ-020 pix_ready  in  1  sink accepts; transfer = pix_valid & pix_ready.
REQ-021 pix_last  out  1  high with final pixel of region.

Function
REQ-022 FSM states IDLE, CHECK, ISSUE, DRAIN, FIN; reset state IDLE.
REQ-023 IDLE: start=1 latches col_start/row_start/width/height, clears err, next CHECK; start in any other state ignored.
REQ-024 CHECK (1 cycle): width==0 or height==0 -> FIN, no reads, no pixels, err=0.
REQ-025 CHECK: col_start+width > FB_COLS or row_start+height > FB_ROWS (9-/8-bit sums, no truncation) -> err=1, FIN, no reads.
REQ-026 CHECK otherwise: column counter i=0, row counter j=0, next ISSUE.
REQ-027 ISSUE order: j fastest (0..height-1), then i (0..width-1); mem_rd_addr = (col_start+i)*FB_ROWS + (row_start+j), 15-bit exact.
REQ-028 Credit rule: mem_rd_en=1 in ISSUE only when (reads in flight + FIFO count) < FIFO_DEPTH; counters advance only on issued read.
REQ-029 After issuing read (width-1, height-1) -> DRAIN.
REQ-030 Read-return pipeline: RD_LATENCY-stage valid shift register; data pushed into FIFO in exact issue order.
REQ-031 FIFO never overflows or underflows; simultaneous push and pop leaves count unchanged.
REQ-032 pix_valid = FIFO non-empty; pix_data/pix_last stable while pix_valid & !pix_ready.
REQ-033 pix_last tagged on the width*height-th pixel only.
REQ-034 Minimum latency: first pix_valid RD_LATENCY+1 cycles after ISSUE entry; sustained 1 pixel/cycle with pix_ready held high.
REQ-035 DRAIN -> FIN when pixel with pix_last transfers; FIN asserts done for 1 cycle, next IDLE.
REQ-036 mem_rd_en=0 outside ISSUE; mem_rd_addr don't-care when mem_rd_en=0.

Reset
REQ-037 rst=1 forces IDLE immediately; busy, done, err, mem_rd_en, pix_valid, pix_last =0; mem_rd_addr, pix_data =0.
REQ-038 Reset mid-operation clears FIFO, counters, and read-pipeline valid bits; in-flight data discarded, never emitted.
REQ-039 First start accepted on the first rising edge after rst deasserts.

Verification
REQ-040 Region col 2,row 3,4x2, pix_ready=1, RAM word=address -> addresses 243,244,363,364,483,484,603,604; 8 pixels same order; pix_last on 8th; done 1 cycle after.
REQ-041 Full frame 0,0,160x120 with pix_ready random 50% -> 19200 pixels, data=address, no loss/duplication, mem_rd_en never violates credit rule.
REQ-042 col_start 150,width 11 -> err=1, done pulse 2 cycles after start, mem_rd_en never high, pix_valid never high.
REQ-043 width=0 -> done, err=0, zero pixels; start during busy -> ignored, current region unaffected.
REQ-044 pix_ready low 20 cycles during 1x10 read -> at most FIFO_DEPTH reads outstanding, pix_data held stable, all 10 delivered after release.
REQ-045 rst pulsed while 3 reads in flight -> outputs zero same cycle; next 1x1 read returns exactly one pixel.
